pipeline_sequencer: RTL and testbench

Central pipeline controller for the 5-stage core.
- Turns hazard-unit requests (load-use stall, taken branch), data-memory handshake status and halt requests into per-stage register enables, flush strobes and the PC enable.
- Runs a start/run/wait/drain/halt state machine.
- Sits between the hazard unit, the data memory interface and the pipeline registers IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipeline_sequencer_if.sv | 48 ++++
 rtl/pipeline_sequencer.sv | 138 +++++++++++++
 tb/tb_pipeline_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_sequencer_if.sv
// Control bundle between the pipeline sequencer and the hazard unit, data memory and pipeline registers.
// Optional performance counters are present when PIPE_PERF_CNT_EN is defined.
interface pipeline_sequencer_if;
    logic        start;
    logic        ld_use_stall;
    logic        branch_taken;
    logic        halt_req;
    logic        mem_req;
    logic        mem_ready;
    logic        pc_en;
    logic        en_ifid;
    logic        en_idex;
    logic        en_exmem;
    logic        en_memwb;
    logic        flush_ifid;
    logic        flush_idex;
    logic        flush_exmem;
    logic        mem_start;
    logic        running;
    logic        halted;
    logic        err;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_events;
`endif

    // Sequencer side: consumes requests, drives the pipeline controls.
    modport master (
        input  start, ld_use_stall, branch_taken, halt_req, mem_req, mem_ready,
        output pc_en, en_ifid, en_idex, en_exmem, en_memwb,
        output flush_ifid, flush_idex, flush_exmem,
        output mem_start, running, halted, err
`ifdef PIPE_PERF_CNT_EN
        , output stall_cycles, flush_events
`endif
    );

    // Pipeline / environment side.
    modport slave (
        output start, ld_use_stall, branch_taken, halt_req, mem_req, mem_ready,
        input  pc_en, en_ifid, en_idex, en_exmem, en_memwb,
        input  flush_ifid, flush_idex, flush_exmem,
        input  mem_start, running, halted, err
`ifdef PIPE_PERF_CNT_EN
        , input stall_cycles, flush_events
`endif
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// Central 5-stage pipeline controller: start/run/wait/drain/halt FSM driving stage enables and flushes.
// Define PIPE_PERF_CNT_EN to add the stall_cycles / flush_events performance counters.
module pipeline_sequencer #(
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_sequencer_if.master bus
);
    localparam int unsigned WaitW  = 8;
    localparam int unsigned DrainW = 4;

    typedef enum logic [2:0] {
        stIdle    = 3'd0,
        stRun     = 3'd1,
        stMemWait = 3'd2,
        stDrain   = 3'd3,
        stHalted  = 3'd4
    } stateT;

    stateT              state, nextState;
    logic [WaitW-1:0]   waitCnt, waitNext;
    logic [DrainW-1:0]  drainCnt, drainNext;
    logic               errQ, errNext;

    // Cycle classification shared by next-state and output decode.
    logic memStall, issueCycle, timeout, drainStall;
    logic takeBranch, takeHalt, takeLdUse;

    assign memStall   = (state == stRun) && bus.mem_req && !bus.mem_ready;
    assign issueCycle = ((state == stRun) && !memStall) || ((state == stMemWait) && bus.mem_ready);
    assign timeout    = (state == stMemWait) && !bus.mem_ready &&
                        (waitCnt == WaitW'(MEM_TIMEOUT - 1));
    assign drainStall = (state == stDrain) && bus.mem_req && !bus.mem_ready;
    assign takeBranch = issueCycle && bus.branch_taken;
    assign takeHalt   = issueCycle && !bus.branch_taken && bus.halt_req;
    assign takeLdUse  = issueCycle && !bus.branch_taken && !bus.halt_req && bus.ld_use_stall;

    // State, counters and sticky error register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= stIdle;
            waitCnt  <= '0;
            drainCnt <= '0;
            errQ     <= 1'b0;
        end else begin
            state    <= nextState;
            waitCnt  <= waitNext;
            drainCnt <= drainNext;
            errQ     <= errNext;
        end
    end

    // Next-state and counter update.
    always_comb begin
        nextState = state;
        waitNext  = waitCnt;
        drainNext = drainCnt;
        errNext   = errQ;
        unique case (state)
            stIdle: if (bus.start) nextState = stRun;
            stRun, stMemWait: begin
                if (memStall) begin
                    nextState = stMemWait;
                    waitNext  = '0;
                end else if (issueCycle) begin
                    nextState = takeHalt ? stDrain : stRun;
                    if (takeHalt) drainNext = '0;
                end else if (timeout) begin
                    nextState = stHalted;
                    errNext   = 1'b1;
                end else begin
                    waitNext = waitCnt + WaitW'(1);
                end
            end
            stDrain: begin
                if (!drainStall) begin
                    if (drainCnt == DrainW'(DRAIN_CYCLES - 1)) nextState = stHalted;
                    else drainNext = drainCnt + DrainW'(1);
                end
            end
            stHalted: begin
                if (bus.start) begin
                    nextState = stRun;
                    errNext   = 1'b0;
                end
            end
            default: nextState = stIdle;
        endcase
    end

    // Combinational output decode of state and current requests.
    always_comb begin
        bus.pc_en       = 1'b0;
        bus.en_ifid     = 1'b0;
        bus.en_idex     = 1'b0;
        bus.en_exmem    = 1'b0;
        bus.en_memwb    = 1'b0;
        bus.flush_ifid  = 1'b0;
        bus.flush_idex  = 1'b0;
        bus.flush_exmem = timeout;
        bus.mem_start   = (state == stRun) && bus.mem_req;
        bus.running     = (state == stRun) || (state == stMemWait) || (state == stDrain);
        bus.halted      = (state == stHalted);
        bus.err         = errQ;
        if (state == stDrain) begin
            bus.flush_ifid = 1'b1;
            bus.en_idex    = !drainStall;
            bus.en_exmem   = !drainStall;
            bus.en_memwb   = !drainStall;
        end
        if (issueCycle) begin
            bus.pc_en    = !(takeHalt || takeLdUse);
            bus.en_ifid  = !(takeHalt || takeLdUse);
            bus.en_idex  = 1'b1;
            bus.en_exmem = 1'b1;
            bus.en_memwb = 1'b1;
            bus.flush_ifid = takeBranch || takeHalt;
            bus.flush_idex = takeBranch || takeLdUse;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // Saturating stall and branch-flush counters, cleared on restart from HALTED.
    always_ff @(posedge clk) begin
        if (rst || ((state == stHalted) && bus.start)) begin
            bus.stall_cycles <= '0;
            bus.flush_events <= '0;
        end else begin
            if (bus.running && !bus.pc_en && (bus.stall_cycles != '1))
                bus.stall_cycles <= bus.stall_cycles + 32'(1);
            if (takeBranch && (bus.flush_events != '1))
                bus.flush_events <= bus.flush_events + 16'(1);
        end
    end
`endif
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: directed test-plan sequences followed by randomized traffic.
module tb_pipeline_sequencer;
    localparam int unsigned MemTimeout  = 16;
    localparam int unsigned DrainCycles = 3;
    localparam int PhIdle = 0, PhRun = 1, PhWaiting = 2, PhDraining = 3, PhStopped = 4;

    typedef struct packed {
        logic       pcEn;
        logic [3:0] en;      // ifid, idex, exmem, memwb
        logic [2:0] flush;   // ifid, idex, exmem
        logic       memStart;
        logic       running;
        logic       halted;
        logic       err;
    } outT;

    typedef struct {
        outT         o;
        bit          maskMemStart;
        int          cyc;
        logic [31:0] st;
        logic [15:0] fe;
    } expT;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_sequencer_if bus();
    pipeline_sequencer #(.MEM_TIMEOUT(MemTimeout), .DRAIN_CYCLES(DrainCycles)) dut (
        .clk(clk), .rst(rst), .bus(bus));

    expT sb[$];
    int checks = 0;
    int errors = 0;
    int cycNo  = 0;

    // Reference model: what the pipeline should do this cycle, from the behavioural rules.
    int          phase;
    int          waited, drained;
    bit          errM;
    logic [31:0] stM;
    logic [15:0] feM;

    task automatic model(input bit s, lu, br, hr, mq, mr, r, output expT e);
        outT o;
        int  nxt;
        bit  brHon;
        o = '0;
        o.err = errM;
        nxt = phase;
        brHon = 0;
        e.maskMemStart = 0;
        e.st = stM;
        e.fe = feM;
        case (phase)
            PhIdle: if (s) nxt = PhRun;
            PhRun, PhWaiting: begin
                o.running = 1;
                if (phase == PhRun) o.memStart = mq;
                if ((phase == PhRun && mq && !mr) || (phase == PhWaiting && !mr)) begin
                    if (phase == PhRun) begin
                        nxt = PhWaiting;
                        waited = 0;
                    end else begin
                        waited++;
                        if (waited == int'(MemTimeout)) begin
                            o.flush[0] = 1;
                            nxt = PhStopped;
                            errM = 1;
                        end
                    end
                end else begin
                    nxt = PhRun;
                    if (br) begin
                        o.pcEn = 1; o.en = 4'b1111; o.flush = 3'b110; brHon = 1;
                    end else if (hr) begin
                        o.en = 4'b0111; o.flush = 3'b100; nxt = PhDraining; drained = 0;
                    end else if (lu) begin
                        o.en = 4'b0111; o.flush = 3'b010;
                    end else begin
                        o.pcEn = 1; o.en = 4'b1111;
                    end
                end
            end
            PhDraining: begin
                o.running = 1;
                o.flush = 3'b100;
                e.maskMemStart = 1;
                if (!(mq && !mr)) begin
                    o.en = 4'b0111;
                    drained++;
                    if (drained == int'(DrainCycles)) nxt = PhStopped;
                end
            end
            default: begin
                o.halted = 1;
                if (s) begin
                    nxt = PhRun; errM = 0; stM = '0; feM = '0;
                end
            end
        endcase
        if (o.running && !o.pcEn && stM != '1) stM = stM + 1;
        if (brHon && feM != '1) feM = feM + 1;
        if (r) begin
            nxt = PhIdle; errM = 0; waited = 0; drained = 0; stM = '0; feM = '0;
        end
        phase = nxt;
        e.o = o;
    endtask

    task automatic drive(input bit s, lu, br, hr, mq, mr, r);
        expT e;
        bus.start = s; bus.ld_use_stall = lu; bus.branch_taken = br;
        bus.halt_req = hr; bus.mem_req = mq; bus.mem_ready = mr;
        rst = r;
        model(s, lu, br, hr, mq, mr, r, e);
        e.cyc = cycNo;
        sb.push_back(e);
        @(posedge clk); #1;
        cycNo++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: the DUT presents a full output vector every cycle; compare mid-cycle.
    always @(negedge clk) begin
        expT e;
        outT got;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            got = {bus.pc_en, bus.en_ifid, bus.en_idex, bus.en_exmem, bus.en_memwb,
                   bus.flush_ifid, bus.flush_idex, bus.flush_exmem,
                   bus.mem_start, bus.running, bus.halted, bus.err};
            if (e.maskMemStart) begin
                got.memStart = 1'b0;
                e.o.memStart = 1'b0;
            end
            checks++;
            if (got !== e.o) begin
                errors++;
                $display("FAIL outputs cyc=%0d got=%b expected=%b (pc en4 fl3 ms run hlt err)",
                         e.cyc, got, e.o);
            end
`ifdef PIPE_PERF_CNT_EN
            checks++;
            if (bus.stall_cycles !== e.st || bus.flush_events !== e.fe) begin
                errors++;
                $display("FAIL perf cyc=%0d got=%0d/%0d expected=%0d/%0d",
                         e.cyc, bus.stall_cycles, bus.flush_events, e.st, e.fe);
            end
`endif
        end
    end

    initial begin
        int readyPct;
        bit s, lu, br, hr, mq, mr, r;
        rst = 1'b1;
        bus.start = 0; bus.ld_use_stall = 0; bus.branch_taken = 0;
        bus.halt_req = 0; bus.mem_req = 0; bus.mem_ready = 0;
        @(posedge clk); #1;
        phase = PhIdle; waited = 0; drained = 0; errM = 0; stM = '0; feM = '0;

        // Reset and idle: everything low until start.
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(2);
        drive(1, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Load-use bubble, then branch beating a simultaneous load-use.
        drive(0, 1, 0, 0, 0, 0, 0);
        idle(1);
        drive(0, 1, 1, 0, 0, 0, 0);
        idle(1);
        // Memory access completing after three wait cycles.
        drive(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 0);
        idle(1);
        // Zero-wait access with branch.
        drive(0, 0, 1, 0, 1, 1, 0);
        // Memory timeout, then restart clears err.
        drive(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < int'(MemTimeout); i++) drive(0, 0, 0, 0, 1, 0, 0);
        idle(2);
        drive(1, 0, 0, 0, 0, 0, 0);
        idle(1);
        // Halt with a two-cycle memory stall during drain.
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Reset in the middle of a memory wait.
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 1);
        idle(2);

        // Randomized traffic with memory-readiness regimes that change every 64 cycles.
        readyPct = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) begin
                case ($urandom_range(0, 2))
                    0: readyPct = 5;
                    1: readyPct = 40;
                    default: readyPct = 90;
                endcase
            end
            s  = ($urandom_range(0, 99) < 8);
            lu = ($urandom_range(0, 99) < 15) && (phase != PhDraining);
            br = ($urandom_range(0, 99) < 10);
            hr = ($urandom_range(0, 99) < 3);
            mq = ($urandom_range(0, 99) < 25) || (phase == PhWaiting);
            mr = ($urandom_range(0, 99) < readyPct);
            r  = ($urandom_range(0, 999) < 3);
            drive(s, lu, br, hr, mq, mr, r);
        end

        @(negedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d expected=0 leftover entries", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
